// File: rtl/kempston_mouse_pkg.sv
// kempston_mouse_pkg: shared port addresses, FSM/select encodings and button byte helper
package kempston_mouse_pkg;
  localparam logic [15:0] DEF_PORT_X   = 16'hFBDF;
  localparam logic [15:0] DEF_PORT_Y   = 16'hFFDF;
  localparam logic [15:0] DEF_PORT_BTN = 16'hFADF;
  typedef enum logic [1:0] {IDLE, SNAP, DRIVE, RELEASE} state_t;
  typedef enum logic [1:0] {SEL_X, SEL_Y, SEL_BTN} sel_t;
  // Kempston button byte: active-low buttons in [2:0], bit 3 always 1, hi nibble supplied by caller
  function automatic logic [7:0] btn_byte(input logic [2:0] button, input logic swap, input logic [3:0] hi);
    logic l, r;
    l = swap ? button[1] : button[0];
    r = swap ? button[0] : button[1];
    return {hi, 1'b1, ~button[2], ~l, ~r};
  endfunction
endpackage

// File: rtl/zx_bus_sync.sv
// zx_bus_sync: per-strobe synchronisers for IORQ/RD/M1, combined read request and its rising edge
module zx_bus_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic iorq_n,
  input  logic rd_n,
  input  logic m1_n,
  output logic req,
  output logic rise
);
  logic [STAGES-1:0] iorq_s, rd_s, m1_s;
  logic prev;
  // chains and edge history preset to "read asserted" so a read in flight across reset is never answered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iorq_s <= '0;
      rd_s   <= '0;
      m1_s   <= '1;
      prev   <= 1'b1;
    end else begin
      iorq_s <= {iorq_s[STAGES-2:0], iorq_n};
      rd_s   <= {rd_s[STAGES-2:0], rd_n};
      m1_s   <= {m1_s[STAGES-2:0], m1_n};
      prev   <= req;
    end
  end
  assign req  = !iorq_s[STAGES-1] && !rd_s[STAGES-1] && m1_s[STAGES-1];
  assign rise = req && !prev;
endmodule

// File: rtl/kempston_mouse_port.sv
// kempston_mouse_port: Z80 Kempston mouse read ports with atomic snapshot; KMOUSE_WHEEL_EN puts wheel in button byte
module kempston_mouse_port
  import kempston_mouse_pkg::*;
#(
  parameter logic [15:0] PORT_X      = DEF_PORT_X,
  parameter logic [15:0] PORT_Y      = DEF_PORT_Y,
  parameter logic [15:0] PORT_BTN    = DEF_PORT_BTN,
  parameter int          SYNC_STAGES = 2,
  parameter int          TIMEOUT     = 255
) (
  input  logic        clk_peripheral,
  input  logic        reset,
  input  logic [7:0]  x,
  input  logic [7:0]  y,
  input  logic [2:0]  button,
  input  logic [3:0]  wheel,
  input  logic        enable,
  input  logic        swap_buttons,
  input  logic [15:0] cpu_a,
  input  logic        cpu_iorq_n,
  input  logic        cpu_rd_n,
  input  logic        cpu_m1_n,
  output logic [7:0]  data_o,
  output logic        data_oe,
  output logic        busy
);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t        state, state_n;
  sel_t          sel, sel_d;
  logic          req, rise, hit;
  logic [3:0]    hi;
  logic [7:0]    btn, snap_x, snap_y, snap_btn;
  logic [CW-1:0] cnt;
`ifdef KMOUSE_WHEEL_EN
  assign hi = wheel;
`else
  logic unused_wheel;
  assign unused_wheel = ^wheel;
  assign hi = 4'hF;
`endif
  zx_bus_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk(clk_peripheral),
    .rst(reset),
    .iorq_n(cpu_iorq_n),
    .rd_n(cpu_rd_n),
    .m1_n(cpu_m1_n),
    .req(req),
    .rise(rise)
  );
  assign btn   = btn_byte(button, swap_buttons, hi);
  assign hit   = cpu_a == PORT_X || cpu_a == PORT_Y || cpu_a == PORT_BTN;
  assign sel_d = cpu_a == PORT_Y ? SEL_Y : cpu_a == PORT_BTN ? SEL_BTN : SEL_X;
  // state register, address select at read start, drive-cycle counter and field snapshot
  always_ff @(posedge clk_peripheral or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      sel      <= SEL_X;
      cnt      <= '0;
      snap_x   <= 8'h00;
      snap_y   <= 8'h00;
      snap_btn <= 8'hFF;
    end else begin
      state <= state_n;
      cnt   <= state == DRIVE ? cnt + CW'(1) : '0;
      if (state == IDLE && rise) sel <= sel_d;
      if (state == SNAP) begin
        snap_x   <= x;
        snap_y   <= y;
        snap_btn <= btn;
      end
    end
  end
  // next state and bus outputs; only DRIVE puts a byte on the bus
  always_comb begin
    state_n = state;
    data_oe = state == DRIVE;
    busy    = state != IDLE;
    data_o  = !data_oe ? 8'hFF : sel == SEL_X ? snap_x : sel == SEL_Y ? snap_y : snap_btn;
    case (state)
      IDLE:    state_n = rise && enable && hit ? SNAP : IDLE;
      SNAP:    state_n = DRIVE;
      DRIVE:   state_n = !req || cnt == CW'(TIMEOUT - 1) ? RELEASE : DRIVE;
      RELEASE: state_n = req ? RELEASE : IDLE;
      default: state_n = IDLE;
    endcase
  end
endmodule
